// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Holds the FSM state enum, the hazard-class enum and the class-to-stall-length map.
package hazard_stall_unit_pkg;

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    MWAIT
  } state_t;

  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_LU,
    HZ_BR_ALU,
    HZ_BR_LD1,
    HZ_BR_LD2
  } hazard_t;

  localparam int ZERO_REG   = 0;
  localparam int HOLD_CNT_W = 2;

  // Number of stall cycles a hazard class costs, counting the detection cycle.
  function automatic logic [HOLD_CNT_W-1:0] stall_len_of(input hazard_t hz);
    logic [HOLD_CNT_W-1:0] len;
    len = HOLD_CNT_W'(0);
    unique case (hz)
      HZ_NONE:   len = HOLD_CNT_W'(0);
      HZ_BR_LD2: len = HOLD_CNT_W'(2);
      default:   len = HOLD_CNT_W'(1);
    endcase
    return len;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_match.sv
// Combinational register compare and hazard classifier for the instruction in ID.
// Reports the most expensive hazard class when several apply at once.
module hazard_stall_unit_match
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_dst,
  output hazard_t           hz_class
);

  logic [REG_AW-1:0] dst [2];
  logic [1:0]        match;

  assign dst[0] = ex_dst;
  assign dst[1] = mem_dst;

  // The zero register is hard-wired, so writes to it never create a dependency.
  for (genvar gi = 0; gi < 2; gi++) begin : g_match
    assign match[gi] = (dst[gi] != REG_AW'(ZERO_REG)) &&
                       ((id_uses_rs && (dst[gi] == id_rs)) ||
                        (id_uses_rt && (dst[gi] == id_rt)));
  end

  logic lu, br_alu, br_ld2, br_ld1;

  assign lu     = ex_mem_read && match[0];
  assign br_alu = id_is_branch && ex_reg_write && !ex_mem_read && match[0];
  assign br_ld2 = id_is_branch && ex_mem_read && match[0];
  assign br_ld1 = id_is_branch && mem_mem_read && match[1];

  always_comb begin
    hz_class = HZ_NONE;
    if (br_ld2)      hz_class = HZ_BR_LD2;
    else if (lu)     hz_class = HZ_LU;
    else if (br_alu) hz_class = HZ_BR_ALU;
    else if (br_ld1) hz_class = HZ_BR_LD1;
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline stall/bubble/freeze controller with memory-wait watchdog.
// Optional stall-cycle performance counter enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              dmem_wait,
  output logic              pc_stall,
  output logic              ifid_hold,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic              timeout_err,
  output logic [31:0]       stall_cycles
);

  hazard_t hz_class;

  hazard_stall_unit_match #(.REG_AW(REG_AW)) u_match (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_branch (id_is_branch),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_dst       (ex_dst),
    .mem_mem_read (mem_mem_read),
    .mem_dst      (mem_dst),
    .hz_class     (hz_class)
  );

  state_t                state_reg, state_next, ret_reg, ret_next, eff_state;
  logic [HOLD_CNT_W-1:0] cnt_reg, cnt_next, n_len;
  logic [CNT_W-1:0]      wd_reg, wd_next;
  logic                  timeout_err_reg, timeout_err_next;
  logic                  stall, freeze;

  assign n_len = stall_len_of(hz_class);

  // On the cycle a memory wait ends, the FSM already behaves as the saved state
  // so a pending HOLD resumes without a dead cycle.
  always_comb begin
    eff_state  = (state_reg == MWAIT) ? ret_reg : state_reg;
    state_next = state_reg;
    ret_next   = ret_reg;
    cnt_next   = cnt_reg;
    stall      = 1'b0;
    freeze     = 1'b0;
    if (dmem_wait) begin
      freeze     = 1'b1;
      state_next = MWAIT;
      ret_next   = eff_state;
    end else if (eff_state == HOLD) begin
      stall      = 1'b1;
      cnt_next   = (cnt_reg == '0) ? '0 : cnt_reg - HOLD_CNT_W'(1);
      state_next = (cnt_reg <= HOLD_CNT_W'(1)) ? RUN : HOLD;
    end else begin
      state_next = RUN;
      stall      = (n_len != '0);
      if (n_len > HOLD_CNT_W'(1)) begin
        state_next = HOLD;
        cnt_next   = n_len - HOLD_CNT_W'(1);
      end
    end
  end

  always_comb begin
    wd_next = '0;
    if (dmem_wait) wd_next = (wd_reg == {CNT_W{1'b1}}) ? wd_reg : wd_reg + CNT_W'(1);
    timeout_err_next = timeout_err_reg || (dmem_wait && (wd_next >= CNT_W'(WAIT_TIMEOUT)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= RUN;
      ret_reg         <= RUN;
      cnt_reg         <= '0;
      wd_reg          <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ret_reg         <= ret_next;
      cnt_reg         <= cnt_next;
      wd_reg          <= wd_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  // Mealy outputs are forced low while reset is held, regardless of inputs.
  assign pc_stall    = !reset && (stall || freeze);
  assign ifid_hold   = !reset && (stall || freeze);
  assign idex_bubble = !reset && stall;
  assign pipe_freeze = !reset && freeze;
  assign timeout_err = timeout_err_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         stall_cnt_reg <= '0;
    else if (pc_stall) stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign stall_cycles = stall_cnt_reg;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed test-plan steps plus random
// traffic against a stall-budget reference model.
module tb_hazard_stall_unit;

  localparam int REG_AW       = 5;
  localparam int WAIT_TIMEOUT = 255;
  localparam int CNT_W        = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] id_rs, id_rt, ex_dst, mem_dst;
  logic              id_uses_rs, id_uses_rt, id_is_branch;
  logic              ex_mem_read, ex_reg_write, mem_mem_read, dmem_wait;
  logic              pc_stall, ifid_hold, idex_bubble, pipe_freeze, timeout_err;
  logic [31:0]       stall_cycles;

  hazard_stall_unit #(
    .REG_AW       (REG_AW),
    .WAIT_TIMEOUT (WAIT_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_branch (id_is_branch),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_dst       (ex_dst),
    .mem_mem_read (mem_mem_read),
    .mem_dst      (mem_dst),
    .dmem_wait    (dmem_wait),
    .pc_stall     (pc_stall),
    .ifid_hold    (ifid_hold),
    .idex_bubble  (idex_bubble),
    .pipe_freeze  (pipe_freeze),
    .timeout_err  (timeout_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: remaining forced stall cycles, consecutive-wait run, sticky error.
  int          hold_left = 0;
  int          wait_run  = 0;
  bit          err_m     = 1'b0;
  logic [31:0] perf_m    = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit reads(input logic [REG_AW-1:0] r);
    return (r != 0) && ((id_uses_rs && r == id_rs) || (id_uses_rt && r == id_rt));
  endfunction

  // Stall length demanded by the ID instruction, largest applicable class wins.
  function automatic int hazard_n();
    int n;
    n = 0;
    if (ex_mem_read && reads(ex_dst) && n < 1) n = 1;
    if (id_is_branch && ex_reg_write && !ex_mem_read && reads(ex_dst) && n < 1) n = 1;
    if (id_is_branch && mem_mem_read && reads(mem_dst) && n < 1) n = 1;
    if (id_is_branch && ex_mem_read && reads(ex_dst)) n = 2;
    return n;
  endfunction

  task automatic model_reset();
    hold_left = 0;
    wait_run  = 0;
    err_m     = 1'b0;
    perf_m    = '0;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_dst = '0; mem_dst = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_is_branch = 0;
    ex_mem_read = 0; ex_reg_write = 0; mem_mem_read = 0; dmem_wait = 0;
  endtask

  // One clock: check Mealy outputs against the model, then advance both.
  task automatic cycle(input string tag);
    int n;
    bit es, ef;
    #1;
    n  = hazard_n();
    ef = dmem_wait;
    es = !dmem_wait && (hold_left > 0 || n > 0);
    check({tag, ".pc_stall"},    {31'd0, pc_stall},    {31'd0, es | ef});
    check({tag, ".ifid_hold"},   {31'd0, ifid_hold},   {31'd0, es | ef});
    check({tag, ".idex_bubble"}, {31'd0, idex_bubble}, {31'd0, es});
    check({tag, ".pipe_freeze"}, {31'd0, pipe_freeze}, {31'd0, ef});
    check({tag, ".timeout_err"}, {31'd0, timeout_err}, {31'd0, err_m});
    check({tag, ".stall_cycles"}, stall_cycles, perf_m);
    $display("cycle %s: wait=%0b n=%0d stall=%0b freeze=%0b err=%0b", tag, ef, n, es, ef, timeout_err);
    @(posedge clk);
    if (dmem_wait) begin
      wait_run++;
      if (wait_run >= WAIT_TIMEOUT) err_m = 1'b1;
    end else begin
      wait_run = 0;
      if (hold_left > 0) hold_left--;
      else if (n > 0) hold_left = n - 1;
    end
`ifdef HAZARD_PERF_CNT_EN
    if (es || ef) perf_m = perf_m + 32'd1;
`endif
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    // Hazard present while in reset: outputs must stay low.
    ex_mem_read = 1; ex_dst = 5; id_rs = 5; id_uses_rs = 1; dmem_wait = 1;
    #3;
    check("rst.pc_stall",     {31'd0, pc_stall},    32'd0);
    check("rst.idex_bubble",  {31'd0, idex_bubble}, 32'd0);
    check("rst.pipe_freeze",  {31'd0, pipe_freeze}, 32'd0);
    check("rst.timeout_err",  {31'd0, timeout_err}, 32'd0);
    check("rst.stall_cycles", stall_cycles,         32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    cycle("idle");

    // Load-use, then the same with the zero register as destination.
    ex_mem_read = 1; ex_dst = 5; id_rs = 5; id_uses_rs = 1;
    cycle("lu");
    clear_inputs();
    cycle("lu_after");
    ex_mem_read = 1; ex_dst = 0; id_rs = 0; id_uses_rs = 1;
    cycle("lu_r0");
    clear_inputs();

    // Branch after load: two stall cycles even with inputs cleared.
    id_is_branch = 1; ex_mem_read = 1; ex_dst = 8; id_rt = 8; id_uses_rt = 1;
    cycle("brld2_a");
    clear_inputs();
    cycle("brld2_b");
    cycle("brld2_c");

    // Branch after ALU op, and branch after load in MEM.
    id_is_branch = 1; ex_reg_write = 1; ex_dst = 3; id_rs = 3; id_uses_rs = 1;
    cycle("bralu");
    clear_inputs();
    cycle("bralu_after");
    id_is_branch = 1; mem_mem_read = 1; mem_dst = 3; id_rs = 3; id_uses_rs = 1;
    cycle("brld1");
    clear_inputs();
    cycle("brld1_after");

    // Memory wait arriving mid-HOLD.
    id_is_branch = 1; ex_mem_read = 1; ex_dst = 8; id_rt = 8; id_uses_rt = 1;
    cycle("mh_detect");
    clear_inputs();
    dmem_wait = 1;
    for (int i = 0; i < 4; i++) cycle("mh_wait");
    dmem_wait = 0;
    cycle("mh_resume");
    cycle("mh_run");

    // Random traffic with small register indices so hits are frequent.
    for (int i = 0; i < 400; i++) begin
      id_rs        = REG_AW'($urandom_range(0, 3));
      id_rt        = REG_AW'($urandom_range(0, 3));
      ex_dst       = REG_AW'($urandom_range(0, 3));
      mem_dst      = REG_AW'($urandom_range(0, 3));
      id_uses_rs   = 1'($urandom_range(0, 1));
      id_uses_rt   = 1'($urandom_range(0, 1));
      id_is_branch = 1'($urandom_range(0, 1));
      ex_mem_read  = 1'($urandom_range(0, 1));
      ex_reg_write = 1'($urandom_range(0, 1));
      mem_mem_read = 1'($urandom_range(0, 1));
      dmem_wait    = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end
    clear_inputs();
    cycle("rand_end");
    cycle("rand_end2");

    // Watchdog: long wait, sticky flag after the wait drops.
    dmem_wait = 1;
    for (int i = 0; i < 300; i++) cycle("wd_wait");
    dmem_wait = 0;
    for (int i = 0; i < 3; i++) cycle("wd_after");

    // Asynchronous reset in the middle of a memory wait.
    dmem_wait = 1;
    cycle("mw_pre");
    cycle("mw_pre2");
    #2 reset = 1'b1;
    #1;
    check("arst.pc_stall",     {31'd0, pc_stall},    32'd0);
    check("arst.ifid_hold",    {31'd0, ifid_hold},   32'd0);
    check("arst.pipe_freeze",  {31'd0, pipe_freeze}, 32'd0);
    check("arst.timeout_err",  {31'd0, timeout_err}, 32'd0);
    check("arst.stall_cycles", stall_cycles,         32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    dmem_wait = 0;
    ex_mem_read = 1; ex_dst = 2; id_rt = 2; id_uses_rt = 1;
    cycle("post_rst_lu");
    clear_inputs();
    cycle("post_rst_idle");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
